// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: valid/ready parallel load, then tick-paced serial shift-out with a done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_tick,
    output logic             o_sdata,
    output logic             o_svalid,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cnt;
    logic             nxt_bit;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign shift_nxt = MSB_FIRST ? {shift[WIDTH-2:0], 1'b0} : {1'b0, shift[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    logic par;
    // parity goes out once every data bit has been consumed
    assign nxt_bit = (cnt == CW'(WIDTH - 1)) ? par : out_bit(shift_nxt);
`else
    assign nxt_bit = out_bit(shift_nxt);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            hold     <= '0;
            shift    <= '0;
            cnt      <= '0;
            o_sdata  <= 1'b0;
            o_svalid <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_ready  <= 1'b0;
`ifdef PISO_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        hold    <= i_d;
`ifdef PISO_PARITY_EN
                        par     <= ^i_d;
`endif
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    shift    <= hold;
                    cnt      <= '0;
                    o_sdata  <= out_bit(hold);
                    o_svalid <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (i_tick) begin
                        shift <= shift_nxt;
                        if (cnt == CW'(LAST)) begin
                            o_sdata  <= 1'b0;
                            o_svalid <= 1'b0;
                            o_done   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            o_sdata <= nxt_bit;
                        end
                    end
                end
                DONE: begin
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// tb_piso_shift_ctrl: directed checks of an LSB-first and an MSB-first controller sharing stimulus.
module tb_piso_shift_ctrl;
`ifdef PISO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 4 + PB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] d = 4'b0;
    logic       ready0, sdata0, svalid0, busy0, done0;
    logic       ready1, sdata1, svalid1, busy1, done1;
    int         n_assert = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_d(d), .i_valid(valid), .o_ready(ready0),
        .i_tick(tick), .o_sdata(sdata0), .o_svalid(svalid0), .o_busy(busy0), .o_done(done0)
    );

    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_d(d), .i_valid(valid), .o_ready(ready1),
        .i_tick(tick), .o_sdata(sdata1), .o_svalid(svalid1), .o_busy(busy1), .o_done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // full LSB-first transfer on dut0 with tick held high; bits[k] is the k-th serial bit
    task automatic send0(input logic [3:0] w, input logic [4:0] bits, input string tag);
        d = w;
        valid = 1'b1;
        tick = 1'b1;
        step;
        chk({tag, "_accept"}, {6'b0, ready0, busy0}, 8'b01);
        valid = 1'b0;
        step;
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), {6'b0, svalid0, sdata0}, {7'b1, bits[k]});
            step;
        end
        chk({tag, "_done"}, {5'b0, done0, svalid0, busy0}, 8'b101);
        step;
        chk({tag, "_rearm"}, {5'b0, done0, ready0, busy0}, 8'b010);
    endtask

    initial begin
        #1;
        chk("rst_out0", {3'b0, ready0, busy0, svalid0, sdata0, done0}, 8'h0);
        chk("rst_out1", {3'b0, ready1, busy1, svalid1, sdata1, done1}, 8'h0);
        step;
        step;
        chk("rst_hold_ready", {6'b0, ready0, ready1}, 8'h0);
        rst = 1'b0;
        step;
        chk("ready_after_rst", {6'b0, ready0, ready1}, 8'b11);

        send0(4'b1011, 5'b11011, "lsb");

        // MSB-first with a tick every third cycle
        d = 4'b1000;
        valid = 1'b1;
        tick = 1'b0;
        step;
        valid = 1'b0;
        step;
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("msb_bit%0d_a", k), {6'b0, svalid1, sdata1}, {7'b1, 1'(5'b10001 >> k)});
            chk($sformatf("lsb_bit%0d_a", k), {6'b0, svalid0, sdata0}, {7'b1, 1'(5'b11000 >> k)});
            step;
            chk($sformatf("msb_bit%0d_b", k), {6'b0, svalid1, sdata1}, {7'b1, 1'(5'b10001 >> k)});
            step;
            chk($sformatf("msb_bit%0d_c", k), {6'b0, svalid1, sdata1}, {7'b1, 1'(5'b10001 >> k)});
            tick = 1'b1;
            step;
            tick = 1'b0;
        end
        chk("sparse_done", {6'b0, done1, done0}, 8'b11);
        step;
        chk("sparse_rearm", {6'b0, done1, ready1}, 8'b01);

        // backpressure: valid stays high and d keeps changing while busy
        d = 4'b0101;
        valid = 1'b1;
        tick = 1'b1;
        step;
        for (int k = 0; k < NB; k++) begin
            d = ~d;
            step;
            chk($sformatf("bp_ready%0d", k), {7'b0, ready0}, 8'b0);
            chk($sformatf("bp_bit%0d", k), {7'b0, sdata0}, {7'b0, 1'(5'b00101 >> k)});
        end
        d = 4'b1001;
        step;
        chk("bp_done", {6'b0, done0, ready0}, 8'b10);
        d = 4'b1100;
        step;
        chk("bp_idle", {6'b0, ready0, busy0}, 8'b10);
        step;
        chk("bp_accept2", {6'b0, ready0, busy0}, 8'b01);
        valid = 1'b0;
        step;
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("bp2_bit%0d", k), {6'b0, svalid0, sdata0}, {7'b1, 1'(5'b01100 >> k)});
            step;
        end
        chk("bp2_done", {7'b0, done0}, 8'b1);
        step;
        chk("bp2_rearm", {7'b0, ready0}, 8'b1);

        // asynchronous reset after two of four bits
        d = 4'b1101;
        valid = 1'b1;
        tick = 1'b1;
        step;
        valid = 1'b0;
        step;
        chk("rs_bit0", {7'b0, sdata0}, 8'b1);
        step;
        chk("rs_bit1", {7'b0, sdata0}, 8'b0);
        step;
        chk("rs_bit2", {7'b0, sdata0}, 8'b1);
        #2 rst = 1'b1;
        #1;
        chk("rs_abort0", {3'b0, ready0, busy0, svalid0, sdata0, done0}, 8'h0);
        chk("rs_abort1", {3'b0, ready1, busy1, svalid1, sdata1, done1}, 8'h0);
        step;
        chk("rs_no_done", {6'b0, done0, done1}, 8'h0);
        rst = 1'b0;
        step;
        chk("rs_ready", {6'b0, ready0, done0}, 8'b10);
        send0(4'b0110, 5'b00110, "post_rst");

        // ticks in IDLE and LOAD are dropped
        tick = 1'b1;
        step;
        chk("it_idle", {5'b0, ready0, busy0, svalid0}, 8'b100);
        d = 4'b0010;
        valid = 1'b1;
        step;
        valid = 1'b0;
        step;
        chk("it_first_bit", {6'b0, svalid0, sdata0}, 8'b10);
        tick = 1'b0;
        step;
        chk("it_first_hold", {6'b0, svalid0, sdata0}, 8'b10);
        tick = 1'b1;
        step;
        chk("it_bit1", {6'b0, svalid0, sdata0}, 8'b11);
        for (int k = 2; k < NB; k++) begin
            step;
            chk($sformatf("it_bit%0d", k), {7'b0, sdata0}, {7'b0, 1'(5'b10010 >> k)});
        end
        step;
        chk("it_done", {7'b0, done0}, 8'b1);
        step;
        chk("it_rearm", {7'b0, ready0}, 8'b1);

`ifdef PISO_PARITY_EN
        send0(4'b0111, 5'b10111, "parity");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
